// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer that owns the HI/LO register pair.
// Accepts mult/multu/div/divu from the E stage. Each op runs for a fixed number
// of busy cycles, then writes its result to HI/LO. The block also handles
// mthi/mtlo, drives HI/LO for mfhi/mflo, and requests a D-stage stall when a
// HI/LO user in D would otherwise see a stale value.
//
// Optional feature: define MD_CANCEL_EN to honour `cancel` (abort an in-flight op).
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   start      in   1   E stage holds a mult/div this cycle
//   md_op      in   2   00 mult, 01 multu, 10 div, 11 divu
//   src_a      in  32   rs operand
//   src_b      in  32   rt operand
//   hi_wr      in   1   mthi in E
//   lo_wr      in   1   mtlo in E
//   wdata      in  32   data for mthi/mtlo
//   md_use_D   in   1   D-stage instr uses the mult/div unit or HI/LO
//   cancel     in   1   abort the in-flight op (MD_CANCEL_EN only)
//   busy       out  1   op in flight (registered)
//   stall_req  out  1   md_use_D & (start | busy), combinational
//   hi         out 32   HI register
//   lo         out 32   LO register
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  input  logic        md_use_D,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  // Abort request, tied off when the cancel feature is not built in
  logic cancel_act;
`ifdef MD_CANCEL_EN
  assign cancel_act = cancel;
`else
  logic cancel_unused;
  assign cancel_unused = cancel;
  assign cancel_act    = 1'b0;
`endif

  // Result datapath, computed from the latched operands
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, quo, rem;
  logic        sgn, div_zero;

  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    sgn      = ~op_q[0];
    div_zero = (b_q == 32'd0);
    abs_a    = (sgn && a_q[31]) ? -a_q : a_q;
    abs_b    = (sgn && b_q[31]) ? -b_q : b_q;
    q_mag    = div_zero ? 32'd0 : abs_a / abs_b;
    r_mag    = div_zero ? 32'd0 : abs_a % abs_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign
    quo      = (sgn && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem      = (sgn && a_q[31]) ? -r_mag : r_mag;
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cancel_act) begin
          // start and mthi/mtlo of this cycle are suppressed
        end else if (start) begin
          // start takes priority over a same-cycle mthi/mtlo
          op_d    = md_op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          if (hi_wr) hi_d = wdata;
          if (lo_wr) lo_d = wdata;
        end
      end
      ST_RUN: begin
        if (cancel_act) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          if (!op_q[1]) begin
            {hi_d, lo_d} = op_q[0] ? prod_u : prod_s;
          end else if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // Covers the start cycle too, so a dependent D-stage instr never reads stale HI/LO
  assign stall_req = md_use_D & (start | busy_q);

endmodule
